// File: rtl/speck_iterative_core_pkg.sv
// Shared constants for the iterative SPECK core: FSM encodings, mode values
// and the default 128/128 parameter set.
package speck_iterative_core_pkg;

  localparam int DEF_WORD_W    = 64;
  localparam int DEF_KEY_WORDS = 2;
  localparam int DEF_NR_ROUNDS = 32;
  localparam int DEF_ALPHA     = 8;
  localparam int DEF_BETA      = 3;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_EXPAND = 4'd1;
  localparam logic [3:0] ST_ROUND  = 4'd2;
  localparam logic [3:0] ST_DONE   = 4'd3;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/speck_iterative_core_if.sv
// Host-side bundle of the SPECK core: request inputs, result and status outputs.
interface speck_iterative_core_if
  import speck_iterative_core_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int KEY_WORDS = DEF_KEY_WORDS
);

  // Handshake: signal_start is a request taken only while the core is idle
  // (busy=0); mode/reload_key/key/data_in are captured on that same edge.
  // finished pulses one cycle when data_out is valid; data_out then holds.
  logic                        signal_start;
  logic                        mode;
  logic                        reload_key;
  logic [KEY_WORDS*WORD_W-1:0] key;
  logic [2*WORD_W-1:0]         data_in;
  logic [2*WORD_W-1:0]         data_out;
  logic                        finished;
  logic                        busy;
  logic                        keys_valid;
  logic [3:0]                  state_response;

  modport master (
    output signal_start, mode, reload_key, key, data_in,
    input  data_out, finished, busy, keys_valid, state_response
  );

  modport slave (
    input  signal_start, mode, reload_key, key, data_in,
    output data_out, finished, busy, keys_valid, state_response
  );

endinterface

// File: rtl/speck_iterative_core_round_unit.sv
// Combinational SPECK round (encrypt or inverse). Also serves the key schedule
// step when fed x=l0, y=k, rk=i in encrypt mode.
module speck_iterative_core_round_unit
  import speck_iterative_core_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ALPHA  = DEF_ALPHA,
  parameter int BETA   = DEF_BETA
) (
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] rk,
  input  logic              mode,
  output logic [WORD_W-1:0] x_next,
  output logic [WORD_W-1:0] y_next
);

  logic [WORD_W-1:0] x_ror, enc_x, enc_y;
  logic [WORD_W-1:0] dec_t, dec_y, dec_u, dec_x;

  always_comb begin
    x_ror = (x >> ALPHA) | (x << (WORD_W - ALPHA));
    enc_x = (x_ror + y) ^ rk;
    enc_y = ((y << BETA) | (y >> (WORD_W - BETA))) ^ enc_x;

    dec_t = y ^ x;
    dec_y = (dec_t >> BETA) | (dec_t << (WORD_W - BETA));
    dec_u = (x ^ rk) - dec_y;
    dec_x = (dec_u << ALPHA) | (dec_u >> (WORD_W - ALPHA));

    x_next = (mode == MODE_DEC) ? dec_x : enc_x;
    y_next = (mode == MODE_DEC) ? dec_y : enc_y;
  end

endmodule

// File: rtl/speck_iterative_core.sv
// Iterative SPECK encrypt/decrypt engine: one round per clock through a single
// round unit, with an on-chip round-key store filled by an expansion pass.
module speck_iterative_core
  import speck_iterative_core_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int KEY_WORDS = DEF_KEY_WORDS,
  parameter int NR_ROUNDS = DEF_NR_ROUNDS,
  parameter int ALPHA     = DEF_ALPHA,
  parameter int BETA      = DEF_BETA
) (
  input logic                   clk,
  input logic                   rst,
  speck_iterative_core_if.slave bus
);

  localparam int CW = (NR_ROUNDS > 1) ? $clog2(NR_ROUNDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NR_ROUNDS - 1);

  logic [3:0]          state;
  logic [CW-1:0]       cnt;
  logic                mode_q;
  logic [WORD_W-1:0]   x_q, y_q, k_q;
  logic [WORD_W-1:0]   l_q [KEY_WORDS-1];
  logic [WORD_W-1:0]   rk_mem [NR_ROUNDS];
  logic [2*WORD_W-1:0] data_out_q;
  logic                finished_q;
  logic                keys_valid_q;

  logic                accept, last;
  logic [CW-1:0]       rk_idx;
  logic [WORD_W-1:0]   ru_x, ru_y, ru_rk, ru_x_next, ru_y_next;
  logic                ru_mode;

  assign accept = (state == ST_IDLE) && bus.signal_start;
  assign last   = (cnt == LAST);
  assign rk_idx = (mode_q == MODE_DEC) ? (LAST - cnt) : cnt;

  // During expansion the round unit computes l_new (x') and the next k (y').
  always_comb begin
    ru_x    = x_q;
    ru_y    = y_q;
    ru_rk   = rk_mem[rk_idx];
    ru_mode = mode_q;
    if (state == ST_EXPAND) begin
      ru_x    = l_q[0];
      ru_y    = k_q;
      ru_rk   = WORD_W'(cnt);
      ru_mode = MODE_ENC;
    end
  end

  speck_iterative_core_round_unit #(
    .WORD_W(WORD_W),
    .ALPHA (ALPHA),
    .BETA  (BETA)
  ) u_round (
    .x     (ru_x),
    .y     (ru_y),
    .rk    (ru_rk),
    .mode  (ru_mode),
    .x_next(ru_x_next),
    .y_next(ru_y_next)
  );

  // Control: state, counter and host-visible status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      data_out_q   <= '0;
      finished_q   <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.signal_start) begin
            cnt <= '0;
            if (bus.reload_key || !keys_valid_q) begin
              state        <= ST_EXPAND;
              keys_valid_q <= 1'b0;
            end else begin
              state <= ST_ROUND;
            end
          end
        end
        ST_EXPAND: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt          <= '0;
            keys_valid_q <= 1'b1;
            state        <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt        <= '0;
            data_out_q <= {ru_x_next, ru_y_next};
            finished_q <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers and the round-key store are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_q <= bus.mode;
      x_q    <= bus.data_in[2*WORD_W-1:WORD_W];
      y_q    <= bus.data_in[WORD_W-1:0];
      k_q    <= bus.key[WORD_W-1:0];
      for (int j = 0; j < KEY_WORDS - 1; j++) begin
        l_q[j] <= bus.key[(j+1)*WORD_W +: WORD_W];
      end
    end else if (state == ST_EXPAND) begin
      rk_mem[cnt] <= k_q;
      k_q         <= ru_y_next;
      for (int j = 0; j < KEY_WORDS - 2; j++) begin
        l_q[j] <= l_q[j+1];
      end
      l_q[KEY_WORDS-2] <= ru_x_next;
    end else if (state == ST_ROUND) begin
      x_q <= ru_x_next;
      y_q <= ru_y_next;
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.finished       = finished_q;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.keys_valid     = keys_valid_q;
  assign bus.state_response = state;

endmodule

// File: tb/tb_speck_iterative_core.sv
// Bench for speck_iterative_core: a 128/128 instance and a 32/64 instance,
// directed known-answer vectors, expected results queued and checked on finished.
module tb_speck_iterative_core;
  import speck_iterative_core_pkg::*;

  localparam int NA = 32;
  localparam int NB = 22;

  localparam logic [127:0] KEY_A = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT_A  = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] CT_A  = 128'ha65d985179783265_7860fedf5c570d18;
  localparam logic [63:0]  KEY_B = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  PT_B  = 32'h6574_694c;
  localparam logic [31:0]  CT_B  = 32'ha868_42f2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   kv_a = 1'b0;
  bit   kv_b = 1'b0;

  logic [127:0] exp_a_q[$];
  int           cyc_a_q[$];
  logic [31:0]  exp_b_q[$];
  int           cyc_b_q[$];
  logic [127:0] e_a;
  logic [31:0]  e_b;
  int           c_a, c_b;

  speck_iterative_core_if #(.WORD_W(64), .KEY_WORDS(2)) if_a ();
  speck_iterative_core_if #(.WORD_W(16), .KEY_WORDS(4)) if_b ();

  speck_iterative_core #(
    .WORD_W(64), .KEY_WORDS(2), .NR_ROUNDS(NA), .ALPHA(8), .BETA(3)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(if_a)
  );

  speck_iterative_core #(
    .WORD_W(16), .KEY_WORDS(4), .NR_ROUNDS(NB), .ALPHA(7), .BETA(2)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(if_b)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: finished observed during cycle cyc+1
  always @(negedge clk) begin
    if (if_a.finished === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_finished actual=pulse@%0d required=none", cyc + 1);
      end else begin
        e_a = exp_a_q.pop_front();
        c_a = cyc_a_q.pop_front();
        chk("a_data", if_a.data_out, e_a);
        chk("a_finish_cycle", 128'(cyc + 1), 128'(c_a));
        chk("a_busy_at_finish", 128'(if_a.busy), 128'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.finished === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_finished actual=pulse@%0d required=none", cyc + 1);
      end else begin
        e_b = exp_b_q.pop_front();
        c_b = cyc_b_q.pop_front();
        chk("b_data", 128'(if_b.data_out), 128'(e_b));
        chk("b_finish_cycle", 128'(cyc + 1), 128'(c_b));
      end
    end
  end

  // Driver tasks
  task automatic go_a(input logic md, input logic rl, input logic [127:0] din,
                      input logic [127:0] expv);
    int s;
    @(negedge clk);
    if_a.mode = md;
    if_a.reload_key = rl;
    if_a.data_in = din;
    if_a.key = KEY_A;
    if_a.signal_start = 1'b1;
    s = cyc + 1;
    exp_a_q.push_back(expv);
    cyc_a_q.push_back(s + ((rl || !kv_a) ? 2*NA + 1 : NA + 1));
    kv_a = 1'b1;
    @(negedge clk);
    if_a.signal_start = 1'b0;
  endtask

  task automatic go_b(input logic md, input logic rl, input logic [31:0] din,
                      input logic [31:0] expv);
    int s;
    @(negedge clk);
    if_b.mode = md;
    if_b.reload_key = rl;
    if_b.data_in = din;
    if_b.key = KEY_B;
    if_b.signal_start = 1'b1;
    s = cyc + 1;
    exp_b_q.push_back(expv);
    cyc_b_q.push_back(s + ((rl || !kv_b) ? 2*NB + 1 : NB + 1));
    kv_b = 1'b1;
    @(negedge clk);
    if_b.signal_start = 1'b0;
  endtask

  task automatic wait_a();
    int n = 0;
    while (exp_a_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_a_q.size() != 0) begin
      bad++;
      $display("FAIL a_timeout actual=%0d_pending required=0", exp_a_q.size());
      exp_a_q.delete();
      cyc_a_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_b();
    int n = 0;
    while (exp_b_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_b_q.size() != 0) begin
      bad++;
      $display("FAIL b_timeout actual=%0d_pending required=0", exp_b_q.size());
      exp_b_q.delete();
      cyc_b_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    if_a.signal_start = 1'b0; if_a.mode = 1'b0; if_a.reload_key = 1'b0;
    if_a.key = '0; if_a.data_in = '0;
    if_b.signal_start = 1'b0; if_b.mode = 1'b0; if_b.reload_key = 1'b0;
    if_b.key = '0; if_b.data_in = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_rst_data_out", if_a.data_out, 128'd0);
    chk("a_rst_finished", 128'(if_a.finished), 128'd0);
    chk("a_rst_busy", 128'(if_a.busy), 128'd0);
    chk("a_rst_keys_valid", 128'(if_a.keys_valid), 128'd0);
    chk("a_rst_state", 128'(if_a.state_response), 128'(ST_IDLE));
    chk("b_rst_data_out", 128'(if_b.data_out), 128'd0);
    chk("b_rst_keys_valid", 128'(if_b.keys_valid), 128'd0);
    chk("b_rst_state", 128'(if_b.state_response), 128'(ST_IDLE));
    rst = 1'b0;

    // 32/64 encrypt with expansion, then decrypt from stored keys
    go_b(1'b0, 1'b1, PT_B, CT_B);
    wait_b();
    chk("b_keys_valid", 128'(if_b.keys_valid), 128'd1);
    go_b(1'b1, 1'b0, CT_B, PT_B);
    wait_b();

    // 128/128 encrypt with expansion
    go_a(1'b0, 1'b1, PT_A, CT_A);
    repeat (3) @(negedge clk);
    chk("a_state_expand", 128'(if_a.state_response), 128'(ST_EXPAND));
    chk("a_keys_invalid_during_expand", 128'(if_a.keys_valid), 128'd0);
    wait_a();
    chk("a_keys_valid", 128'(if_a.keys_valid), 128'd1);
    chk("a_idle_after_done", 128'(if_a.state_response), 128'(ST_IDLE));

    // Decrypt with stored keys
    go_a(1'b1, 1'b0, CT_A, PT_A);
    wait_a();

    // Start pulses and altered operands while busy must be ignored
    go_a(1'b0, 1'b0, PT_A, CT_A);
    repeat (4) @(negedge clk);
    chk("a_state_round", 128'(if_a.state_response), 128'(ST_ROUND));
    chk("a_busy_in_round", 128'(if_a.busy), 128'd1);
    if_a.data_in = ~PT_A;
    if_a.mode = 1'b1;
    if_a.reload_key = 1'b1;
    if_a.signal_start = 1'b1;
    @(negedge clk);
    if_a.signal_start = 1'b0;
    repeat (3) @(negedge clk);
    if_a.signal_start = 1'b1;
    repeat (3) @(negedge clk);
    if_a.signal_start = 1'b0;
    wait_a();

    // Reset in the middle of expansion
    @(negedge clk);
    if_a.mode = 1'b0;
    if_a.reload_key = 1'b1;
    if_a.data_in = PT_A;
    if_a.signal_start = 1'b1;
    @(negedge clk);
    if_a.signal_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("a_state_expand_pre_rst", 128'(if_a.state_response), 128'(ST_EXPAND));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    kv_a = 1'b0;
    kv_b = 1'b0;
    chk("a_abort_data_out", if_a.data_out, 128'd0);
    chk("a_abort_finished", 128'(if_a.finished), 128'd0);
    chk("a_abort_busy", 128'(if_a.busy), 128'd0);
    chk("a_abort_keys_valid", 128'(if_a.keys_valid), 128'd0);
    chk("a_abort_state", 128'(if_a.state_response), 128'(ST_IDLE));
    go_a(1'b0, 1'b0, PT_A, CT_A);
    wait_a();

    // start held high across three blocks
    @(negedge clk);
    if_a.mode = 1'b0;
    if_a.reload_key = 1'b0;
    if_a.data_in = PT_A;
    if_a.signal_start = 1'b1;
    s = cyc + 1;
    exp_a_q.push_back(CT_A); cyc_a_q.push_back(s + NA + 1);
    exp_a_q.push_back(CT_A); cyc_a_q.push_back(s + NA + 1 + (NA + 2));
    exp_a_q.push_back(CT_A); cyc_a_q.push_back(s + NA + 1 + 2*(NA + 2));
    repeat (2*(NA + 2) + 1) @(negedge clk);
    if_a.signal_start = 1'b0;
    wait_a();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
